// File: rtl/lane_ser_pkg.sv
// Shared lane-array types: vector width, {a,b} pair record and serializer state.
package lane_ser_pkg;
   localparam int SIZE  = 8;
   localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

   typedef logic [SIZE-1:0] lane_vec_t;

   typedef struct packed {
      lane_vec_t a;
      lane_vec_t b;
   } lane_pair_t;

   typedef enum logic { IDLE, SHIFT } ser_state_t;
endpackage

// File: rtl/lane_ser_fifo.sv
// Synchronous FIFO of lane pairs; the caller guarantees no push when full and no pop when empty.
module lane_ser_fifo
   import lane_ser_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             push,
   input  logic             pop,
   input  lane_pair_t       wdata,
   output lane_pair_t       rdata,
   output logic [CNT_W-1:0] count
);

   lane_pair_t       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // NOTE: the storage array has no reset; count and the pointers alone say which entries are live.
   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/lane_pair_serializer.sv
// Buffers {a,b} lane vectors and streams them LSB-first, one lane pair per beat.
// Optional saturating drop counter: define LANE_PAIR_SERIALIZER_DROPCNT_EN.
module lane_pair_serializer
   import lane_ser_pkg::*;
#(
   parameter  int DEPTH  = 4,
   parameter  int DROP_W = 16,
   localparam int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   input  logic [SIZE-1:0]   i_a,
   input  logic [SIZE-1:0]   i_b,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_a_bit,
   output logic              o_b_bit,
   output logic [IDX_W-1:0]  o_idx,
   output logic              o_last,
   output logic              o_overflow,
   output logic [DROP_W-1:0] o_drop_cnt
);

   localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

   ser_state_t       state;
   ser_state_t       state_nxt;
   logic [CNT_W-1:0] count;
   lane_pair_t       head;
   lane_pair_t       sh;
   logic [IDX_W-1:0] idx;
   logic             push;
   logic             pop;
   logic             drop;
   logic             vec_done;

   // No pop-bypass: a full FIFO drops the capture even if it pops this cycle.
   assign push     = i_valid && (count < FULL);
   assign drop     = i_valid && (count == FULL);
   assign vec_done = (state == SHIFT) && i_ready && (idx == LAST_IDX);
   assign pop      = (count != '0) && ((state == IDLE) || vec_done);

   lane_ser_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .push  (push),
      .pop   (pop),
      .wdata ({i_a, i_b}),
      .rdata (head),
      .count (count)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: default assignment first so no path through this block infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (count != '0) state_nxt = SHIFT;
         SHIFT:   if (vec_done && (count == '0)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_valid = 1'b0;
      o_a_bit = 1'b0;
      o_b_bit = 1'b0;
      o_idx   = '0;
      o_last  = 1'b0;
      if (state == SHIFT) begin
         o_valid = 1'b1;
         o_a_bit = sh.a[idx];
         o_b_bit = sh.b[idx];
         o_idx   = idx;
         o_last  = (idx == LAST_IDX);
      end
   end

   // Shift register reloads on every pop, so back-to-back vectors have no bubble.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sh  <= '0;
         idx <= '0;
      end else if (pop) begin
         sh  <= head;
         idx <= '0;
      end else if ((state == SHIFT) && i_ready) begin
         idx <= vec_done ? '0 : idx + IDX_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) o_overflow <= 1'b0;
      else       o_overflow <= drop;
   end

`ifdef LANE_PAIR_SERIALIZER_DROPCNT_EN
   always_ff @(posedge i_clk) begin
      if (i_rst)
         o_drop_cnt <= '0;
      else if (drop && (o_drop_cnt != '1))
         o_drop_cnt <= o_drop_cnt + DROP_W'(1);
   end
`else
   assign o_drop_cnt = '0;
`endif

endmodule
